// File: rtl/riffa_chnl_host_if.sv
// RIFFA channel signal bundle. The master modport is the host end, the slave
// modport is the bridge end.
interface riffa_chnl_host_if #(
  parameter int C_PCI_DATA_WIDTH = 32
);
  logic                        CHNL_RX;
  logic                        CHNL_RX_ACK;
  logic [31:0]                 CHNL_RX_LEN;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
  logic                        CHNL_RX_DATA_VALID;
  logic                        CHNL_RX_DATA_REN;
  logic                        CHNL_TX;
  logic                        CHNL_TX_ACK;
  logic [31:0]                 CHNL_TX_LEN;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
  logic                        CHNL_TX_DATA_VALID;
  logic                        CHNL_TX_DATA_REN;

  modport master (
    output CHNL_RX, CHNL_RX_LEN, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
           CHNL_TX_ACK, CHNL_TX_DATA_REN,
    input  CHNL_RX_ACK, CHNL_RX_DATA_REN, CHNL_TX, CHNL_TX_LEN,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID
  );

  modport slave (
    input  CHNL_RX, CHNL_RX_LEN, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
           CHNL_TX_ACK, CHNL_TX_DATA_REN,
    output CHNL_RX_ACK, CHNL_RX_DATA_REN, CHNL_TX, CHNL_TX_LEN,
           CHNL_TX_DATA, CHNL_TX_DATA_VALID
  );
endinterface

// File: rtl/riffa_chnl_host.sv
// Host-side RIFFA channel endpoint: feeds RX transactions from a source AHIR
// pipe and drains TX transactions into a sink AHIR pipe.
module riffa_chnl_host #(
  parameter int C_PCI_DATA_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic [31:0]                 start_len,
  output logic                        rx_busy,
  output logic                        rx_done,
  output logic                        tx_done,
  output logic                        tx_err,
  riffa_chnl_host_if.master           chnl,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_pipe_read_data,
  output logic                        src_pipe_read_req,
  input  logic                        src_pipe_read_ack,
  output logic [C_PCI_DATA_WIDTH-1:0] sink_pipe_write_data,
  output logic                        sink_pipe_write_req,
  input  logic                        sink_pipe_write_ack
);
  localparam logic [31:0] NUM_WORDS = 32'(C_PCI_DATA_WIDTH / 32);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} r_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ACK, T_DATA} t_state_t;

  r_state_t r_state, r_state_nxt;
  t_state_t t_state, t_state_nxt;
  logic     rx_done_nxt, tx_done_nxt, tx_err_nxt;

  logic [31:0]                 r_len, r_issued, r_sent;
  logic [31:0]                 t_len, t_count;
  logic [C_PCI_DATA_WIDTH-1:0] hold;
  logic                        hold_full;

  logic rx_valid, rx_beat, rd_fire, tx_in_data, tx_fire;

  assign rx_valid   = hold_full && (r_state == R_DATA);
  assign rx_beat    = rx_valid && chnl.CHNL_RX_DATA_REN;
  assign rd_fire    = src_pipe_read_req && src_pipe_read_ack;
  assign tx_in_data = (t_state == T_DATA);
  assign tx_fire    = tx_in_data && chnl.CHNL_TX_DATA_VALID && sink_pipe_write_ack;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= R_IDLE;
      t_state <= T_IDLE;
      rx_done <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      t_state <= t_state_nxt;
      rx_done <= rx_done_nxt;
      tx_done <= tx_done_nxt;
      tx_err  <= tx_err_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rx_done_nxt = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (start) begin
          if (start_len == 32'd0) rx_done_nxt = 1'b1;
          else                    r_state_nxt = R_REQ;
        end
      end
      R_REQ: begin
        if (chnl.CHNL_RX_ACK) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (rx_beat && (r_sent + NUM_WORDS >= r_len)) begin
          r_state_nxt = R_IDLE;
          rx_done_nxt = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // A completing beat wins over a simultaneous CHNL_TX drop.
  always_comb begin
    t_state_nxt = t_state;
    tx_done_nxt = 1'b0;
    tx_err_nxt  = 1'b0;
    case (t_state)
      T_IDLE: begin
        if (chnl.CHNL_TX) t_state_nxt = T_ACK;
      end
      T_ACK: begin
        if (t_len == 32'd0) begin
          t_state_nxt = T_IDLE;
          tx_done_nxt = 1'b1;
        end else begin
          t_state_nxt = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_fire && (t_count + NUM_WORDS >= t_len)) begin
          t_state_nxt = T_IDLE;
          tx_done_nxt = 1'b1;
        end else if (!chnl.CHNL_TX) begin
          t_state_nxt = T_IDLE;
          tx_err_nxt  = 1'b1;
        end
      end
      default: t_state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    rx_busy                 = (r_state != R_IDLE);
    chnl.CHNL_RX            = (r_state != R_IDLE);
    chnl.CHNL_RX_LEN        = r_len;
    chnl.CHNL_RX_DATA       = hold;
    chnl.CHNL_RX_DATA_VALID = rx_valid;
    // Refill the one-beat holder only when it is empty or being drained now.
    src_pipe_read_req       = (r_state == R_DATA) && (r_issued < r_len) &&
                              (!hold_full || rx_beat);
  end

  always_comb begin
    chnl.CHNL_TX_ACK      = (t_state == T_ACK);
    chnl.CHNL_TX_DATA_REN = tx_in_data && sink_pipe_write_ack;
    sink_pipe_write_req   = tx_in_data && chnl.CHNL_TX_DATA_VALID;
    sink_pipe_write_data  = tx_in_data ? chnl.CHNL_TX_DATA : '0;
  end

  // The holder is cleared on reset so CHNL_RX_DATA reads zero while in reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_len     <= '0;
      r_issued  <= '0;
      r_sent    <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      t_len     <= '0;
      t_count   <= '0;
    end else begin
      if ((r_state == R_IDLE) && start) begin
        r_len     <= start_len;
        r_issued  <= '0;
        r_sent    <= '0;
        hold_full <= 1'b0;
      end else begin
        if (rd_fire) begin
          hold      <= src_pipe_read_data;
          hold_full <= 1'b1;
          r_issued  <= r_issued + NUM_WORDS;
        end else if (rx_beat) begin
          hold_full <= 1'b0;
        end
        if (rx_beat) r_sent <= r_sent + NUM_WORDS;
      end

      if ((t_state == T_IDLE) && chnl.CHNL_TX) begin
        t_len   <= chnl.CHNL_TX_LEN;
        t_count <= '0;
      end else if (tx_fire) begin
        t_count <= t_count + NUM_WORDS;
      end
    end
  end
endmodule
